// File: rtl/memory_access.sv
// RV32I memory-access stage: issues one bus transaction per load/store with a
// request/ack handshake, steers byte lanes, extends load data and owns MEM/WB.
module memory_access #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              instruction,
  input  logic [AddrWidth-1:0]     instruction_address,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [DataWidth-1:0]     reg2_data,
  input  logic                     memory_read_enable,
  input  logic                     memory_write_enable,
  input  logic [2:0]               funct3,
  input  logic [1:0]               regs_write_source,
  input  logic                     reg_write_enable,
  input  logic [4:0]               reg_write_address,
  output logic                     bus_request,
  output logic                     bus_write,
  output logic [AddrWidth-1:0]     bus_address,
  output logic [DataWidth-1:0]     bus_write_data,
  output logic [DataWidth/8-1:0]   bus_write_strobe,
  input  logic                     bus_ack,
  input  logic [DataWidth-1:0]     bus_read_data,
  output logic                     mem_stall,
  output logic                     mem_fault,
  output logic [31:0]              wb_instruction,
  output logic [AddrWidth-1:0]     wb_instruction_address,
  output logic [DataWidth-1:0]     wb_alu_result,
  output logic [DataWidth-1:0]     wb_memory_read_data,
  output logic [1:0]               wb_regs_write_source,
  output logic                     wb_reg_write_enable,
  output logic [4:0]               wb_reg_write_address
);
  localparam int NumLanes = DataWidth / 8;
  localparam int OffW     = $clog2(NumLanes);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state;

  logic                 r_bus_request, r_bus_write, r_mem_fault, r_load;
  logic [AddrWidth-1:0] r_bus_address;
  logic [DataWidth-1:0] r_bus_write_data;
  logic [NumLanes-1:0]  r_bus_write_strobe;
  logic [2:0]           r_funct3;
  logic [OffW-1:0]      r_offset;
  logic [31:0]          r_instr, r_wb_instr;
  logic [AddrWidth-1:0] r_instr_addr, r_wb_instr_addr;
  logic [DataWidth-1:0] r_alu, r_wb_alu, r_wb_mem_data;
  logic [1:0]           r_wsrc, r_wb_wsrc;
  logic                 r_wen, r_wb_wen;
  logic [4:0]           r_waddr, r_wb_waddr;

  logic                 w_mem_op, w_is_byte, w_is_half, w_misaligned, w_issue, w_fault, w_sext;
  logic [NumLanes-1:0]  w_strobe;
  logic [DataWidth-1:0] w_wdata, w_load_data;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;

  // funct3[1:0] picks the size; every encoding other than B/H behaves as a word
  assign w_mem_op     = in_valid & (memory_read_enable | memory_write_enable);
  assign w_is_byte    = (funct3[1:0] == 2'b00);
  assign w_is_half    = (funct3[1:0] == 2'b01);
  assign w_misaligned = (w_is_half & alu_result[0]) |
                        (!w_is_byte & !w_is_half & (|alu_result[1:0]));
  assign w_issue      = (r_state == IDLE) & w_mem_op & !w_misaligned;
  assign w_fault      = (r_state == IDLE) & w_mem_op & w_misaligned;
  assign mem_stall    = w_issue | ((r_state == BUSY) & !bus_ack);

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    assign w_strobe[l] = w_is_byte ? (alu_result[OffW-1:0] == OffW'(l))
                       : w_is_half ? (alu_result[1] == (((l / 2) % 2) == 1))
                       : 1'b1;
    assign w_wdata[8*l +: 8] = w_is_byte ? reg2_data[7:0]
                             : w_is_half ? reg2_data[8*(l%2) +: 8]
                             : reg2_data[8*l +: 8];
  end

  assign w_byte = bus_read_data[{r_offset, 3'b000} +: 8];
  assign w_half = bus_read_data[{r_offset[OffW-1], 4'b0000} +: 16];
  assign w_sext = ~r_funct3[2];

  always_comb begin
    w_load_data = bus_read_data;
    case (r_funct3[1:0])
      2'b00:   w_load_data = {{(DataWidth-8){w_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{(DataWidth-16){w_sext & w_half[15]}}, w_half};
      default: w_load_data = bus_read_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state            <= IDLE;
      r_bus_request      <= 1'b0;
      r_bus_write        <= 1'b0;
      r_bus_address      <= '0;
      r_bus_write_data   <= '0;
      r_bus_write_strobe <= '0;
      r_mem_fault        <= 1'b0;
      r_load             <= 1'b0;
      r_funct3           <= '0;
      r_offset           <= '0;
      r_instr            <= '0;
      r_instr_addr       <= '0;
      r_alu              <= '0;
      r_wsrc             <= '0;
      r_wen              <= 1'b0;
      r_waddr            <= '0;
      r_wb_instr         <= '0;
      r_wb_instr_addr    <= '0;
      r_wb_alu           <= '0;
      r_wb_mem_data      <= '0;
      r_wb_wsrc          <= '0;
      r_wb_wen           <= 1'b0;
      r_wb_waddr         <= '0;
    end else begin
      r_mem_fault     <= w_fault;
      // MEM/WB takes a bubble unless a result retires this cycle
      r_wb_instr      <= '0;
      r_wb_instr_addr <= '0;
      r_wb_alu        <= '0;
      r_wb_mem_data   <= '0;
      r_wb_wsrc       <= '0;
      r_wb_wen        <= 1'b0;
      r_wb_waddr      <= '0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state            <= BUSY;
            r_bus_request      <= 1'b1;
            r_bus_write        <= memory_write_enable;
            r_bus_address      <= {alu_result[AddrWidth-1:OffW], OffW'(0)};
            r_bus_write_data   <= memory_write_enable ? w_wdata : '0;
            r_bus_write_strobe <= memory_write_enable ? w_strobe : '0;
            r_load             <= memory_read_enable;
            r_funct3           <= funct3;
            r_offset           <= alu_result[OffW-1:0];
            r_instr            <= instruction;
            r_instr_addr       <= instruction_address;
            r_alu              <= alu_result;
            r_wsrc             <= regs_write_source;
            r_wen              <= reg_write_enable;
            r_waddr            <= reg_write_address;
          end else if (in_valid && !w_mem_op) begin
            r_wb_instr      <= instruction;
            r_wb_instr_addr <= instruction_address;
            r_wb_alu        <= alu_result;
            r_wb_wsrc       <= regs_write_source;
            r_wb_wen        <= reg_write_enable;
            r_wb_waddr      <= reg_write_address;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            r_state         <= IDLE;
            r_bus_request   <= 1'b0;
            r_wb_instr      <= r_instr;
            r_wb_instr_addr <= r_instr_addr;
            r_wb_alu        <= r_alu;
            r_wb_mem_data   <= r_load ? w_load_data : '0;
            r_wb_wsrc       <= r_wsrc;
            r_wb_wen        <= r_wen;
            r_wb_waddr      <= r_waddr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_request            = r_bus_request;
  assign bus_write              = r_bus_write;
  assign bus_address            = r_bus_address;
  assign bus_write_data         = r_bus_write_data;
  assign bus_write_strobe       = r_bus_write_strobe;
  assign mem_fault              = r_mem_fault;
  assign wb_instruction         = r_wb_instr;
  assign wb_instruction_address = r_wb_instr_addr;
  assign wb_alu_result          = r_wb_alu;
  assign wb_memory_read_data    = r_wb_mem_data;
  assign wb_regs_write_source   = r_wb_wsrc;
  assign wb_reg_write_enable    = r_wb_wen;
  assign wb_reg_write_address   = r_wb_waddr;
endmodule
